// File: rtl/alu_mdu.sv
// EX-stage ALU with operand/forwarding muxes plus an iterative RV32M multiply/divide unit.
// Base ops and divide special cases finish in one cycle; other M-ops take XLEN iterations.
module alu_mdu #(
    parameter  int XLEN = 32,
    localparam int SHW  = $clog2(XLEN),
    localparam int CW   = $clog2(XLEN + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      ALUCtl,
    input  logic            ALUASrc,
    input  logic [1:0]      ALUBSrc,
    input  logic [1:0]      forwardA,
    input  logic [1:0]      forwardB,
    input  logic [XLEN-1:0] ReadData1,
    input  logic [XLEN-1:0] ReadData2,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] ImmGenOut,
    input  logic [XLEN-1:0] ALUResult_EX_MEM_out,
    input  logic [XLEN-1:0] RegWriteData,
    input  logic            flush,
    output logic            out_valid,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            Less,
    output logic            busy
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    state_t              state_q, state_d;
    logic [XLEN-1:0]     op_a_q, op_a_d;
    logic [XLEN-1:0]     op_b_q, op_b_d;
    logic [2*XLEN-1:0]   prod_q, prod_d;
    logic [XLEN-1:0]     rem_q, rem_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [2:0]          mop_q, mop_d;
    logic                neg_res_q, neg_res_d;
    logic                neg_rem_q, neg_rem_d;
    logic [XLEN-1:0]     res_q, res_d;
    logic                zero_q, zero_d;
    logic                less_q, less_d;

    logic [XLEN-1:0]     src_a, src_b, opa, opb;
    logic [XLEN-1:0]     base_res;
    logic                base_less;
    logic                accept;

    // M-op decode on the live operands
    logic [2:0]          f3;
    logic                div_signed, a_signed, b_signed, a_neg, b_neg;
    logic                b_zero, div_ovf, div_special;
    logic [XLEN-1:0]     special_res, a_mag, b_mag;

    // One iteration step computed from the registered state
    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_next, mul_fix;
    logic [XLEN:0]       div_shift, div_diff;
    logic                div_ge;
    logic [XLEN-1:0]     div_rem_next, div_quo_next, quo_fix, rem_fix;
    logic [XLEN-1:0]     iter_res;

    logic                load_res;
    logic [XLEN-1:0]     fin_res;
    logic                fin_less;

    // Operand source selection followed by forwarding override
    always_comb begin
        src_a = ALUASrc ? pc : ReadData1;
        case (ALUBSrc)
            2'b00:   src_b = ReadData2;
            2'b01:   src_b = ImmGenOut;
            2'b10:   src_b = XLEN'(4);
            default: src_b = '0;
        endcase
        case (forwardA)
            2'b00:   opa = src_a;
            2'b10:   opa = ALUResult_EX_MEM_out;
            2'b01:   opa = RegWriteData;
            default: opa = '0;
        endcase
        case (forwardB)
            2'b00:   opb = src_b;
            2'b10:   opb = ALUResult_EX_MEM_out;
            2'b01:   opb = RegWriteData;
            default: opb = '0;
        endcase
    end

    always_comb begin
        base_res  = '0;
        base_less = 1'b0;
        case (ALUCtl[3:0])
            4'b0000: base_res = opa + opb;
            4'b1000: base_res = opa - opb;
            4'b0001: base_res = opa << opb[SHW-1:0];
            4'b0010: begin
                base_less = $signed(opa) < $signed(opb);
                base_res  = {{(XLEN-1){1'b0}}, base_less};
            end
            4'b1010: begin
                base_less = opa < opb;
                base_res  = {{(XLEN-1){1'b0}}, base_less};
            end
            4'b0100: base_res = opa ^ opb;
            4'b0101: base_res = opa >> opb[SHW-1:0];
            4'b1101: base_res = $unsigned($signed(opa) >>> opb[SHW-1:0]);
            4'b0110: base_res = opa | opb;
            4'b0111: base_res = opa & opb;
            4'b0011: base_res = opb;
            default: base_res = '0;
        endcase
    end

    always_comb begin
        f3          = ALUCtl[2:0];
        div_signed  = f3[2] & ~f3[0];
        a_signed    = (f3 == 3'b001) | (f3 == 3'b010) | div_signed;
        b_signed    = (f3 == 3'b001) | div_signed;
        a_neg       = a_signed & opa[XLEN-1];
        b_neg       = b_signed & opb[XLEN-1];
        a_mag       = a_neg ? (~opa + 1'b1) : opa;
        b_mag       = b_neg ? (~opb + 1'b1) : opb;
        b_zero      = (opb == '0);
        div_ovf     = div_signed & (opa == MIN_VAL) & (&opb);
        div_special = f3[2] & (b_zero | div_ovf);
        // Divide by zero: quotient all-ones, remainder = dividend; overflow: quotient MIN, remainder 0
        if (b_zero) begin
            special_res = f3[1] ? opa : '1;
        end else begin
            special_res = f3[1] ? '0 : MIN_VAL;
        end
    end

    always_comb begin
        mul_sum      = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, op_b_q} : '0);
        mul_next     = {mul_sum, prod_q[XLEN-1:1]};
        mul_fix      = neg_res_q ? (~mul_next + 1'b1) : mul_next;
        div_shift    = {rem_q, op_a_q[XLEN-1]};
        div_diff     = div_shift - {1'b0, op_b_q};
        div_ge       = (div_shift >= {1'b0, op_b_q});
        div_rem_next = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
        div_quo_next = {op_a_q[XLEN-2:0], div_ge};
        quo_fix      = neg_res_q ? (~div_quo_next + 1'b1) : div_quo_next;
        rem_fix      = neg_rem_q ? (~div_rem_next + 1'b1) : div_rem_next;
        if (mop_q[2]) begin
            iter_res = mop_q[1] ? rem_fix : quo_fix;
        end else begin
            iter_res = (mop_q[1:0] == 2'b00) ? mul_fix[XLEN-1:0] : mul_fix[2*XLEN-1:XLEN];
        end
    end

    assign in_ready  = (state_q != S_BUSY) & ~flush & ~rst;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_BUSY);
    assign ALUResult = res_q;
    assign Zero      = zero_q;
    assign Less      = less_q;

    always_comb begin
        state_d   = state_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        prod_d    = prod_q;
        rem_d     = rem_q;
        cnt_d     = cnt_q;
        mop_d     = mop_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        res_d     = res_q;
        zero_d    = zero_q;
        less_d    = less_q;
        load_res  = 1'b0;
        fin_res   = '0;
        fin_less  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (accept) begin
                    if (!ALUCtl[4] || div_special) begin
                        load_res = 1'b1;
                        fin_res  = ALUCtl[4] ? special_res : base_res;
                        fin_less = ALUCtl[4] ? 1'b0 : base_less;
                        state_d  = S_DONE;
                    end else begin
                        state_d   = S_BUSY;
                        cnt_d     = CW'(XLEN);
                        mop_d     = f3;
                        neg_res_d = a_neg ^ b_neg;
                        neg_rem_d = a_neg;
                        op_a_d    = a_mag;
                        op_b_d    = b_mag;
                        prod_d    = {{XLEN{1'b0}}, a_mag};
                        rem_d     = '0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 1'b1;
                if (mop_q[2]) begin
                    op_a_d = div_quo_next;
                    rem_d  = div_rem_next;
                end else begin
                    prod_d = mul_next;
                end
                if (cnt_q == CW'(1)) begin
                    load_res = 1'b1;
                    fin_res  = iter_res;
                    state_d  = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flushed op never registers its result
        if (flush) begin
            state_d = S_IDLE;
        end else if (load_res) begin
            res_d  = fin_res;
            zero_d = (fin_res == '0);
            less_d = fin_less;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_a_q    <= '0;
            op_b_q    <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            mop_q     <= '0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            res_q     <= '0;
            zero_q    <= 1'b0;
            less_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            prod_q    <= prod_d;
            rem_q     <= rem_d;
            cnt_q     <= cnt_d;
            mop_q     <= mop_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            res_q     <= res_d;
            zero_q    <= zero_d;
            less_q    <= less_d;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Randomized self-checking bench for alu_mdu against an arithmetic reference model,
// plus directed flush, asynchronous-reset and 16-bit width cases.
module tb_alu_mdu;
    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      ALUCtl;
    logic            ALUASrc;
    logic [1:0]      ALUBSrc, forwardA, forwardB;
    logic [31:0]     ReadData1, ReadData2, pc, ImmGenOut, ALUResult_EX_MEM_out, RegWriteData;
    logic            flush;
    logic            out_valid;
    logic [31:0]     ALUResult;
    logic            Zero, Less, busy;

    logic            h_rst, h_in_valid, h_in_ready, h_out_valid, h_zero, h_less, h_busy;
    logic [4:0]      h_ctl;
    logic [15:0]     h_rd1, h_rd2, h_res;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_mdu #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .ALUCtl(ALUCtl), .ALUASrc(ALUASrc), .ALUBSrc(ALUBSrc),
        .forwardA(forwardA), .forwardB(forwardB),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .pc(pc), .ImmGenOut(ImmGenOut),
        .ALUResult_EX_MEM_out(ALUResult_EX_MEM_out), .RegWriteData(RegWriteData),
        .flush(flush), .out_valid(out_valid), .ALUResult(ALUResult),
        .Zero(Zero), .Less(Less), .busy(busy)
    );

    alu_mdu #(.XLEN(16)) dut16 (
        .clk(clk), .rst(h_rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .ALUCtl(h_ctl), .ALUASrc(1'b0), .ALUBSrc(2'b00),
        .forwardA(2'b00), .forwardB(2'b00),
        .ReadData1(h_rd1), .ReadData2(h_rd2), .pc(16'h0), .ImmGenOut(16'h0),
        .ALUResult_EX_MEM_out(16'h0), .RegWriteData(16'h0),
        .flush(1'b0), .out_valid(h_out_valid), .ALUResult(h_res),
        .Zero(h_zero), .Less(h_less), .busy(h_busy)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] model_a();
        logic [31:0] s;
        s = ALUASrc ? pc : ReadData1;
        case (forwardA)
            2'b00:   return s;
            2'b10:   return ALUResult_EX_MEM_out;
            2'b01:   return RegWriteData;
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] model_b();
        logic [31:0] s;
        case (ALUBSrc)
            2'b00:   s = ReadData2;
            2'b01:   s = ImmGenOut;
            2'b10:   s = 32'd4;
            default: s = 32'd0;
        endcase
        case (forwardB)
            2'b00:   return s;
            2'b10:   return ALUResult_EX_MEM_out;
            2'b01:   return RegWriteData;
            default: return 32'h0;
        endcase
    endfunction

    // Reference: RISC-V semantics with native 64-bit arithmetic
    task automatic ref_op(input logic [4:0] ctl, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic l, output int lat);
        int signed   sa, sb;
        longint      p;
        logic [63:0] up;
        sa = a; sb = b;
        r = 0; l = 0; lat = 0;
        if (!ctl[4]) begin
            case (ctl[3:0])
                4'b0000: r = a + b;
                4'b1000: r = a - b;
                4'b0001: r = a << b[4:0];
                4'b0010: begin l = (sa < sb); r = {31'b0, l}; end
                4'b1010: begin l = (a < b);   r = {31'b0, l}; end
                4'b0100: r = a ^ b;
                4'b0101: r = a >> b[4:0];
                4'b1101: r = sa >>> b[4:0];
                4'b0110: r = a | b;
                4'b0111: r = a & b;
                4'b0011: r = b;
                default: r = 0;
            endcase
        end else begin
            lat = XLEN;
            case (ctl[2:0])
                3'b000: r = a * b;
                3'b001: begin p = longint'(sa) * longint'(sb); r = p[63:32]; end
                3'b010: begin p = longint'(sa) * longint'({32'b0, b}); r = p[63:32]; end
                3'b011: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
                3'b100: begin
                    if (b == 0) begin r = 32'hFFFF_FFFF; lat = 0; end
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 0; end
                    else r = sa / sb;
                end
                3'b101: begin
                    if (b == 0) begin r = 32'hFFFF_FFFF; lat = 0; end
                    else r = a / b;
                end
                3'b110: begin
                    if (b == 0) begin r = a; lat = 0; end
                    else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 0; end
                    else r = sa % sb;
                end
                default: begin
                    if (b == 0) begin r = a; lat = 0; end
                    else r = a % b;
                end
            endcase
        end
    endtask

    // Call at a point between edges with the block ready; leaves the DUT in DONE.
    task automatic run_op(input logic [4:0] ctl, input string tag);
        logic [31:0] ea, eb, er;
        logic        el;
        int          exp_lat, lat, nbusy;
        ea = model_a();
        eb = model_b();
        ref_op(ctl, ea, eb, er, el, exp_lat);
        ALUCtl   = ctl;
        in_valid = 1'b1;
        #1;
        check({tag, ".ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        lat = 0; nbusy = 0;
        while (!out_valid && lat < 100) begin
            if (busy) nbusy++;
            tick();
            lat++;
        end
        check({tag, ".lat"}, lat, exp_lat);
        check({tag, ".busy"}, nbusy, exp_lat);
        check({tag, ".res"}, ALUResult, er);
        check({tag, ".zero"}, Zero, (er == 0));
        check({tag, ".less"}, Less, el);
        $display("op %s ctl=%b a=%h b=%h res=%h lat=%0d", tag, ctl, ea, eb, ALUResult, lat);
    endtask

    task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
        ALUASrc = 0; ALUBSrc = 2'b00; forwardA = 2'b00; forwardB = 2'b00;
        ReadData1 = a; ReadData2 = b;
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return $urandom_range(0, 40);
            6: return 32'hFFFF_FFFF - $urandom_range(0, 40);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int cnt;
        rst = 1; in_valid = 0; flush = 0; ALUCtl = 0;
        ALUASrc = 0; ALUBSrc = 0; forwardA = 0; forwardB = 0;
        ReadData1 = 0; ReadData2 = 0; pc = 0; ImmGenOut = 0;
        ALUResult_EX_MEM_out = 0; RegWriteData = 0;
        h_rst = 1; h_in_valid = 0; h_ctl = 0; h_rd1 = 0; h_rd2 = 0;

        tick(); tick();
        check("rst.res", ALUResult, 0);
        check("rst.valid", out_valid, 0);
        check("rst.busy", busy, 0);
        check("rst.ready", in_ready, 0);
        check("rst.zero", Zero, 0);
        check("rst.less", Less, 0);
        rst = 0; h_rst = 0;
        #1;
        check("rel.ready", in_ready, 1);
        tick();
        check("rel.valid", out_valid, 0);

        // Directed cases from the plan, including back-to-back base ops
        set_ops(5, 0); ALUBSrc = 2'b01; ImmGenOut = 7;
        run_op(5'b00000, "add");
        ReadData1 = 7;
        run_op(5'b01000, "sub");
        forwardA = 2'b10; ALUResult_EX_MEM_out = 32'hFFFF_FFFF; ImmGenOut = 1;
        run_op(5'b00010, "slt");
        run_op(5'b01010, "sltu");
        set_ops(32'hFFFF_FFFF, 2);
        run_op(5'b10011, "mulhu");
        run_op(5'b10000, "mul");
        set_ops(-3, 5);       run_op(5'b10001, "mulh");
        set_ops(-7, 2);       run_op(5'b10100, "div");
        run_op(5'b10110, "rem");
        set_ops(7, 0);        run_op(5'b10101, "divu0");
        set_ops(32'h8000_0000, 32'hFFFF_FFFF);
        run_op(5'b10100, "divovf");
        run_op(5'b10110, "removf");
        tick();
        check("pulse.valid", out_valid, 0);

        // Flush mid DIVU: accept at edge k, flush during cycle k+10
        set_ops(100, 7); ALUCtl = 5'b10101; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (9) tick();
        flush = 1;
        #1;
        check("flush.ready_busy", in_ready, 0);
        check("flush.busy", busy, 1);
        tick();
        flush = 0;
        #1;
        check("flush.ready_after", in_ready, 1);
        check("flush.busy_after", busy, 0);
        cnt = 0;
        repeat (40) begin if (out_valid) cnt++; tick(); end
        check("flush.no_valid", cnt, 0);
        set_ops(1, 0); ALUBSrc = 2'b01; ImmGenOut = 1;
        run_op(5'b00000, "add_after_flush");

        // flush beats a simultaneous accept in IDLE
        tick();
        set_ops(3, 4); ALUCtl = 5'b00000; in_valid = 1; flush = 1;
        #1;
        check("flush_acc.ready", in_ready, 0);
        tick();
        in_valid = 0; flush = 0;
        check("flush_acc.valid", out_valid, 0);
        check("flush_acc.hold", ALUResult, 2);

        // Asynchronous reset between edges during a MUL
        set_ops(32'h12345, 3); ALUCtl = 5'b10000; in_valid = 1;
        tick();
        in_valid = 0;
        repeat (5) tick();
        #2;
        rst = 1;
        #1;
        check("arst.res", ALUResult, 0);
        check("arst.valid", out_valid, 0);
        check("arst.busy", busy, 0);
        check("arst.ready", in_ready, 0);
        tick();
        rst = 0;
        #1;
        check("arst.ready_rel", in_ready, 1);
        cnt = 0;
        repeat (40) begin if (out_valid) cnt++; tick(); end
        check("arst.no_valid", cnt, 0);

        // Randomized traffic through all muxes and opcodes
        for (int i = 0; i < 150; i++) begin
            logic [4:0] ctl;
            ALUASrc  = $urandom_range(0, 1);
            ALUBSrc  = $urandom_range(0, 3);
            forwardA = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2'b00;
            forwardB = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 2'b00;
            ReadData1 = rnd_val(); ReadData2 = rnd_val(); pc = rnd_val();
            ImmGenOut = rnd_val(); ALUResult_EX_MEM_out = rnd_val(); RegWriteData = rnd_val();
            if ($urandom_range(0, 1) == 0) ctl = {1'b0, 4'($urandom_range(0, 15))};
            else                           ctl = {2'b10, 3'($urandom_range(0, 7))};
            run_op(ctl, "rnd");
        end

        // 16-bit instance: MULHU(0xFFFF,2) -> 1 at k+17, MUL -> 0xFFFE
        h_rd1 = 16'hFFFF; h_rd2 = 16'h2;
        for (int j = 0; j < 2; j++) begin
            h_ctl = (j == 0) ? 5'b10011 : 5'b10000;
            h_in_valid = 1;
            tick();
            h_in_valid = 0;
            cnt = 0;
            while (!h_out_valid && cnt < 100) begin tick(); cnt++; end
            check("x16.lat", cnt, 16);
            check("x16.res", h_res, (j == 0) ? 16'h0001 : 16'hFFFE);
            $display("op x16 ctl=%b res=%h lat=%0d", h_ctl, h_res, cnt);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised successor to the single-cycle EX-stage ALU: same base op set, operand-select muxes and forwarding muxes, plus an iterative RV32M multiply/divide datapath.
- Operands are captured on a valid/ready handshake. The result is registered and signalled by a one-cycle out_valid pulse.
- Sits in EX between the ID/EX and EX/MEM registers. The hazard unit stalls IF/ID/EX while busy=1.

Parameters:
- XLEN, 32, datapath width; power of two, at least 8.
- SHW, $clog2(XLEN), shift-amount width; derived, not overridden.
- CW, $clog2(XLEN+1), iteration counter width; derived.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operation presented this cycle.
- in_ready  out  1  block can accept an operation this cycle.
- ALUCtl  in  5  bit4=0: base op in [3:0]; bit4=1: M-op, funct3 in [2:0].
- ALUASrc  in  1  A source: 1 selects pc, 0 selects ReadData1.
- ALUBSrc  in  2  B source: 00 ReadData2, 01 ImmGenOut, 10 constant 4, 11 zero.
- forwardA, forwardB  in  2 each  forwarding select: 00 selected source, 10 ALUResult_EX_MEM_out, 01 RegWriteData, 11 zero.
- ReadData1, ReadData2, pc, ImmGenOut, ALUResult_EX_MEM_out, RegWriteData  in  XLEN each  operand sources.
- flush  in  1  synchronous kill of any in-flight operation.
- out_valid  out  1  result registers valid this cycle (one-cycle pulse).
- ALUResult  out  XLEN  registered result.
- Zero  out  1  registered (ALUResult==0).
- Less  out  1  registered compare bit; 0 for every op other than SLT/SLTU.
- busy  out  1  iterative operation in flight (state BUSY).

Behaviour:
- Operand selection and forwarding are combinational and identical to the current ALU. Final A/B are latched into internal regs on accept (in_valid & in_ready).
- Base ops (ALUCtl[3:0]):
  - ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 1010, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, LOADIMM 0011 (result=B).
  - Any other code: result 0.
  - Shifts use B[SHW-1:0].
  - Arithmetic wraps modulo 2^XLEN.
- M-ops (ALUCtl[2:0]): MUL 000 (low half), MULH 001 (s×s), MULHSU 010 (s×u), MULHU 011 (u×u), DIV 100, DIVU 101, REM 110, REMU 111.
- FSM states: IDLE, BUSY, DONE.
  - IDLE/DONE + accept of base op or special-case div: compute in the accept cycle, register result, go to DONE.
  - IDLE/DONE + accept of other M-op: go to BUSY, cnt=XLEN.
  - IDLE/DONE + no accept: go to IDLE.
  - BUSY: one shift-add (mul) or one restoring-division step per cycle on operand magnitudes. cnt decrements each cycle. At cnt==1, apply sign fix-up, register result, go to DONE.
  - Any state + flush: go to IDLE next edge. No out_valid is produced for the killed op. flush takes priority over a simultaneous accept, which is dropped.
- Handshake and timing:
  - in_ready = (state==IDLE or DONE) & ~flush. in_ready is 0 in BUSY.
  - out_valid = (state==DONE).
  - Accept in cycle k: base/special result has out_valid in cycle k+1. Iterative result has out_valid in cycle k+XLEN+1.
  - Back-to-back base ops give one result per cycle.
- Division special cases (1-cycle path, RISC-V semantics):
  - Divisor 0: DIV/DIVU give all-ones; REM/REMU give the dividend.
  - Signed overflow (A=MIN, B=-1): DIV gives MIN; REM gives 0.
- Signed division signs: quotient is negated when operand signs differ; remainder takes the sign of the dividend.
- Less: SLT is signed A<B, SLTU is unsigned A<B. Less is registered with the result.
- ALUResult, Zero and Less hold their values until the next result is registered.
- Reset (asynchronous, any state, including mid-iteration):
  - state IDLE; ALUResult 0; Zero 0; Less 0; out_valid 0; busy 0.
  - Internal operand, product and remainder regs cleared; cnt 0.
  - in_ready is 0 while rst=1, and 1 in the first cycle after release.
- No latches: every combinational output is assigned on all paths.

Test Plan:
- ADD: ReadData1=5, ImmGenOut=7, ALUBSrc=01 → next cycle out_valid=1, ALUResult=12, Zero=0. Then SUB with 7−7 back-to-back → ALUResult=0, Zero=1, one cycle later.
- Forwarding and SLT: forwardA=10, ALUResult_EX_MEM_out=0xFFFFFFFF, B=1 → Less=1, ALUResult=1. Same operands with SLTU → Less=0, ALUResult=0.
- MULHU: 0xFFFFFFFF × 2 → busy=1 for 32 cycles, out_valid in cycle k+33, ALUResult=1. MUL on the same operands → 0xFFFFFFFE. MULH(-3,5) → 0xFFFFFFFF.
- DIV/REM: DIV(-7,2) → 0xFFFFFFFD; REM(-7,2) → 0xFFFFFFFF; DIVU(7,0) → 0xFFFFFFFF in 1 cycle; DIV(0x80000000, 0xFFFFFFFF) → 0x80000000 in 1 cycle, with REM → 0.
- Flush: assert flush at cycle k+10 of DIVU(100,7) → no out_valid, in_ready=1 the following cycle. A new ADD(1,1) then returns 2.
- Reset: assert rst mid-MUL, asynchronously between edges → outputs go to 0 immediately. After release, state is IDLE with no stale out_valid. Repeat with XLEN=16: MULHU(0xFFFF,2) → 1 at k+17.
